// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, feeding a small
// first-word-fall-through FIFO. The 6502 reads it through the floppy
// toplevel register decode.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ce         clock enable; qualifies rd and clr_err only
//   uart_rxd   asynchronous serial input, idle high
//   rd         pop request (acts when ce=1)
//   clr_err    clear sticky error flags (acts when ce=1)
//   rx_data    FIFO head byte, 8'h00 when empty
//   rx_avail   FIFO non-empty
//   rx_count   bytes held, 0..2**FIFO_AW
//   overrun    sticky: byte dropped because the FIFO was full
//   frame_err  sticky: stop bit sampled low
//
// State    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line idle, waiting for a low sample on a tick
// START    | counting to the middle of the start bit to reject glitches
// DATA     | sampling 8 data bits at sc=15, LSB first
// STOP     | sampling the stop bit; push on high, frame error on low
// WAITHI   | after a frame error, wait for the line to return high

module uart_rx_fifo #(
    parameter int SYS_CLK  = 24000000,
    parameter int BAUDRATE = 115200,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               uart_rxd,
    input  logic               rd,
    input  logic               clr_err,
    output logic [7:0]         rx_data,
    output logic               rx_avail,
    output logic [FIFO_AW:0]   rx_count,
    output logic               overrun,
    output logic               frame_err
);

    localparam int DIV   = (SYS_CLK + BAUDRATE * 8) / (BAUDRATE * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        WAITHI = 3'd4
    } state_t;

    // synchroniser
    logic rxs_meta_q, rxs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxs_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
        end else begin
            rxs_meta_q <= uart_rxd;
            rxs_q      <= rxs_meta_q;
        end
    end

    // oversampling tick
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // receiver FSM
    state_t     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       armed_q, armed_d;
    logic       push;
    logic       ferr_set;

    // The synchroniser resets high, so a line held low through reset would
    // look like a start edge. armed_q blocks the first start until the line
    // has been seen high on a tick.
    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        armed_d  = armed_q | (tick & rxs_q);
        push     = 1'b0;
        ferr_set = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q && armed_q) begin
                        state_d = START;
                        sc_d    = 4'd0;
                    end
                end
                START: begin
                    if (sc_q == 4'd7) begin
                        if (rxs_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            sc_d    = 4'd0;
                            bit_d   = 3'd0;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                DATA: begin
                    if (sc_q == 4'd15) begin
                        shift_d = {rxs_q, shift_q[7:1]};
                        sc_d    = 4'd0;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                STOP: begin
                    if (sc_q == 4'd15) begin
                        sc_d = 4'd0;
                        if (rxs_q) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = WAITHI;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                WAITHI: begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sc_q    <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    // FIFO
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop, full, wr_en, ovr_set;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;
    logic               clr;

    assign pop     = ce & rd & (count_q != '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en   = push & (~full | pop);
    assign ovr_set = push & full & ~pop;
    assign clr     = ce & clr_err;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
        // set beats clear when both happen in one cycle
        overrun_d   = ovr_set  | (overrun_q   & ~clr);
        frame_err_d = ferr_set | (frame_err_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // storage needs no reset; rx_data is forced to 0 while empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign rx_avail  = (count_q != '0);
    assign rx_count  = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table of receive/pop/clear operations with
// expected outputs, plus hand-written sequences for push+pop on a full
// FIFO and reset in the middle of a frame.
module tb_uart_rx_fifo;

    localparam int DIV = 13;    // (24000000 + 921600) / 1843200
    localparam int BIT = 208;   // 16 * DIV clocks per bit

    localparam int OP_SEND   = 0;
    localparam int OP_BAD    = 1;
    localparam int OP_POP    = 2;
    localparam int OP_CLR    = 3;
    localparam int OP_GLITCH = 4;

    logic       clk;
    logic       reset_n;
    logic       ce;
    logic       uart_rxd;
    logic       rd;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic [3:0] rx_count;
    logic       overrun;
    logic       frame_err;

    int checks;
    int errors;
    int tb_div;

    typedef struct {
        int         op;
        logic [7:0] data;
        logic       ce_v;
        logic [3:0] exp_cnt;
        logic [7:0] exp_data;
        logic       exp_avail;
        logic       exp_ovr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[$];

    uart_rx_fifo #(
        .SYS_CLK (24000000),
        .BAUDRATE(115200),
        .FIFO_AW (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .uart_rxd (uart_rxd),
        .rd       (rd),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_count (rx_count),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench copy of the baud divider phase, used only to place frame edges
    // at a known offset from the oversampling tick.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_div <= 0;
        else          tb_div <= (tb_div == DIV - 1) ? 0 : tb_div + 1;
    end

    function automatic void add(input int op, input logic [7:0] d, input logic c,
                                input logic [3:0] cnt, input logic [7:0] dat,
                                input logic av, input logic ov, input logic fe);
        vec_t v;
        v.op = op; v.data = d; v.ce_v = c;
        v.exp_cnt = cnt; v.exp_data = dat; v.exp_avail = av;
        v.exp_ovr = ov; v.exp_ferr = fe;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] cnt, input logic [7:0] dat,
                             input logic av, input logic ov, input logic fe);
        check({name, " rx_count"},  32'(rx_count),  32'(cnt));
        check({name, " rx_data"},   32'(rx_data),   32'(dat));
        check({name, " rx_avail"},  32'(rx_avail),  32'(av));
        check({name, " overrun"},   32'(overrun),   32'(ov));
        check({name, " frame_err"}, 32'(frame_err), 32'(fe));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves time #1 after a clock edge on which the divider wrapped.
    task automatic align();
        @(posedge clk);
        #1;
        while (tb_div != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame edge at #1 after tick edge E0: start detected at E13, mid start
    // at E117, stop sampled and byte pushed at E1989. pop_at_push drives
    // ce&rd during the cycle that ends at E1989.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input bit pop_at_push);
        logic [7:0] bb;
        bb = b;
        align();
        uart_rxd = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = bb[i];
            wait_clk(BIT);
        end
        uart_rxd = stop_lvl;
        if (pop_at_push) begin
            wait_clk(116);
            ce = 1'b1; rd = 1'b1;
            wait_clk(1);
            ce = 1'b0; rd = 1'b0;
            wait_clk(91);
        end else begin
            wait_clk(BIT);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        wait_clk(BIT);
        uart_rxd = 1'b1;
        wait_clk(40);
    endtask

    task automatic do_pop(input logic c);
        ce = c; rd = 1'b1;
        wait_clk(1);
        ce = 1'b0; rd = 1'b0;
        wait_clk(2);
    endtask

    task automatic do_clr(input logic c);
        ce = c; clr_err = 1'b1;
        wait_clk(1);
        ce = 1'b0; clr_err = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        logic [7:0] exp_head [8];

        checks = 0;
        errors = 0;

        // basic receive and pop
        add(OP_SEND,   8'h55, 1'b1, 4'd2 - 4'd1, 8'h55, 1'b1, 1'b0, 1'b0);
        add(OP_SEND,   8'hA3, 1'b1, 4'd2, 8'h55, 1'b1, 1'b0, 1'b0);
        add(OP_POP,    8'h00, 1'b0, 4'd2, 8'h55, 1'b1, 1'b0, 1'b0);
        add(OP_POP,    8'h00, 1'b1, 4'd1, 8'hA3, 1'b1, 1'b0, 1'b0);
        add(OP_POP,    8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(OP_POP,    8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        // glitch rejection, then a good byte
        add(OP_GLITCH, 8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(OP_SEND,   8'h5A, 1'b1, 4'd1, 8'h5A, 1'b1, 1'b0, 1'b0);
        add(OP_POP,    8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        // framing error is sticky until ce&clr_err
        add(OP_BAD,    8'h41, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(OP_SEND,   8'h42, 1'b1, 4'd1, 8'h42, 1'b1, 1'b0, 1'b1);
        add(OP_CLR,    8'h00, 1'b0, 4'd1, 8'h42, 1'b1, 1'b0, 1'b1);
        add(OP_CLR,    8'h00, 1'b1, 4'd1, 8'h42, 1'b1, 1'b0, 1'b0);
        add(OP_POP,    8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        // overrun: 9 bytes into 8 slots, 09 dropped
        for (int i = 1; i <= 9; i++)
            add(OP_SEND, 8'(i), 1'b1, (i <= 8) ? 4'(i) : 4'd8, 8'h01, 1'b1, (i == 9), 1'b0);
        for (int i = 1; i <= 8; i++)
            add(OP_POP, 8'h00, 1'b1, 4'(8 - i), (i < 8) ? 8'(i + 1) : 8'h00, (i < 8), 1'b1, 1'b0);
        add(OP_CLR,    8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        ce       = 1'b0;
        rd       = 1'b0;
        clr_err  = 1'b0;
        #23;
        check_all("reset", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_clk(20);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_SEND:   send_frame(vecs[i].data, 1'b1, 1'b0);
                OP_BAD:    send_bad(vecs[i].data);
                OP_POP:    do_pop(vecs[i].ce_v);
                OP_CLR:    do_clr(vecs[i].ce_v);
                default: begin
                    align();
                    uart_rxd = 1'b0;
                    wait_clk(39);
                    uart_rxd = 1'b1;
                    wait_clk(300);
                end
            endcase
            check_all($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_data,
                      vecs[i].exp_avail, vecs[i].exp_ovr, vecs[i].exp_ferr);
        end

        // push and pop on the same cycle while full: no overrun
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
        check_all("full", 4'd8, 8'h20, 1'b1, 1'b0, 1'b0);
        send_frame(8'h10, 1'b1, 1'b1);
        check_all("pushpop", 4'd8, 8'h21, 1'b1, 1'b0, 1'b0);
        exp_head = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h10};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d head", i), 32'(rx_data), 32'(exp_head[i]));
            do_pop(1'b1);
        end
        check_all("drained", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // reset in the middle of DATA with the line held low across release
        send_frame(8'h33, 1'b1, 1'b0);
        send_bad(8'h41);
        check_all("prereset", 4'd1, 8'h33, 1'b1, 1'b0, 1'b1);
        align();
        uart_rxd = 1'b0;
        wait_clk(500);
        reset_n = 1'b0;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(1);
        check_all("midreset", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_clk(2200);
        check_all("heldlow", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        uart_rxd = 1'b1;
        wait_clk(300);
        send_frame(8'h7E, 1'b1, 1'b0);
        check_all("after_reset", 4'd1, 8'h7E, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side counterpart of the floppy workhorse console UART transmitter.
- Deserialises 8N1 frames from a UART RX pin using 16x oversampling and buffers received bytes in a small FIFO.
- Exposes data and status to the 6502 through the PORT_RXD / PORT_CTL register decode in the floppy toplevel.
- Reports framing errors and overruns as sticky flags.

Parameters:
- SYS_CLK, 24000000: clk frequency in Hz.
- BAUDRATE, 115200: line rate in baud.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8 bytes.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; qualifies rd and clr_err only
- uart_rxd  in  1  asynchronous serial input, idle high
- rd  in  1  pop request; acts when ce=1
- clr_err  in  1  clear sticky error flags; acts when ce=1
- rx_data  out  8  FIFO head byte (first-word-fall-through)
- rx_avail  out  1  FIFO non-empty
- rx_count  out  FIFO_AW+1  number of bytes held, 0..8
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- frame_err  out  1  sticky: a stop bit was sampled low

Behaviour:
- Reset (async, reset_n=0):
  - rx_avail=0, rx_count=0, overrun=0, frame_err=0, rx_data=8'h00.
  - FIFO pointers 0; FSM in IDLE; synchroniser flops set to 1.
  - Reset mid-frame discards the partial byte. After release, reception restarts only on a fresh 1->0 edge.
- Synchroniser: uart_rxd passes through two flops (rxs) before any use.
- Tick generator:
  - DIV = (SYS_CLK + BAUDRATE*8) / (BAUDRATE*16), integer; default DIV = 13.
  - Free-running counter 0..DIV-1; tick is asserted for one clk when the counter equals DIV-1.
  - Sample counter sc[3:0] advances on ticks only.
- FSM (all transitions on tick cycles):
  - IDLE: if rxs=0, go to START with sc=0.
  - START: when sc=7 (mid start bit), rxs=1 means a glitch -> IDLE with no error. Otherwise go to DATA with sc=0 and bit index 0.
  - DATA: when sc=15, sample rxs into the shift register LSB-first (bit0 first). After bit index 7, go to STOP with sc=0.
  - STOP: when sc=15:
    - rxs=1: push the byte into the FIFO, go to IDLE.
    - rxs=0: set frame_err, discard the byte, go to WAITHI.
  - WAITHI: stay until rxs=1, then go to IDLE. A held-low line or break produces exactly one frame_err.
- Latency: the pushed byte is visible (rx_avail=1, rx_data valid) on the clk edge after the stop-sample tick.
- FIFO:
  - rx_data = mem[rd_ptr] when non-empty, 8'h00 when empty.
  - Pop on ce&rd with count>0; pop when empty is ignored with no underflow.
  - Push when count=8 and no simultaneous pop: set overrun, drop the byte, leave contents unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. When full this is not an overrun.
  - Pointers wrap modulo 2**FIFO_AW; count is the true occupancy.
- Error flags:
  - ce&clr_err clears both flags.
  - If an error event occurs in the same cycle as clr_err, the set wins.
  - Flags never affect FIFO contents.
- ce=0 freezes only the effect of rd and clr_err; reception continues.

Test Plan:
- Send 8'h55 then 8'hA3 at 115200 (208 clk/bit) -> after the second stop bit: rx_count=2, rx_data=8'h55. After a ce&rd pulse: rx_data=8'hA3. After another pop: rx_avail=0, rx_data=8'h00.
- Pulse uart_rxd low for 3 bit-ticks (39 clk) -> no byte is pushed, frame_err=0, FSM back in IDLE.
- Send 8'h41 with the stop bit held low, then release -> frame_err=1, rx_count=0. Send 8'h42 normally -> rx_data=8'h42 with frame_err still 1. ce&clr_err -> frame_err=0.
- Send 9 bytes 8'h01..8'h09 without reading -> rx_count=8, overrun=1, and popping yields 01..08 (09 dropped).
- With the FIFO full, assert ce&rd on the exact push cycle of byte 8'h10 -> overrun stays 0, rx_count stays 8, and the last entry is 8'h10.
- Assert reset_n=0 mid-DATA of a byte, then release while the line is still low -> no byte is pushed and all outputs are at reset values. The next clean frame 8'h7E is received correctly.
